start_referee: RTL and testbench
================================

// Module: start_referee
// PURPOSE
//  Round referee for Tug of War. Consumes the serial LFSR bit and its slow tick,
//  builds a random start delay, counts it down, then raises go. Reports fouls
//  (a press before go) and which player pressed first after go.
//  Sits between the random bit generator and the score/rope logic.
// PARAMETERS
//  DELAY_BITS     4   random bits gathered per round; delay field width
//  MIN_DELAY      2   constant added to the random value, in ticks; < 2**DELAY_BITS
//  TIMEOUT_TICKS  32  ticks in GO with no press before timeout (TIMEOUT_EN only)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  slow_en    in   1  one-clk-wide tick pulse, same pulse that advances the LFSR
//  rand_bit   in   1  LFSR serial output; sampled only on cycles with slow_en=1
//  start      in   1  one-clk pulse: begin a round
//  btn_l      in   1  left player press, one-clk pulse (synced/debounced upstream)
//  btn_r      in   1  right player press, one-clk pulse
//  go         out  1  level, high while waiting for the first press
//  foul_l     out  1  level, left pressed early; held until next start
//  foul_r     out  1  level, right pressed early; held until next start
//  first_l    out  1  one-clk pulse, left pressed first after go
//  first_r    out  1  one-clk pulse, right pressed first after go
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, all outputs 0, shift reg and counter 0.
//  States: IDLE, GATHER, WAIT, GO, FOUL. All outputs are registered.
//  IDLE: start -> GATHER; clears bit count and shift reg. Buttons ignored.
//  GATHER: on each slow_en, shift rand_bit in MSB-first. After DELAY_BITS
//   ticks, load cnt = value + MIN_DELAY (width DELAY_BITS+1, no overflow);
//   go to WAIT, or straight to GO if cnt==0.
//  WAIT: on each slow_en, cnt decrements. On the tick where cnt==1, go to GO.
//   go rises the clk after that tick (delay = value+MIN_DELAY ticks after GATHER).
//  GATHER/WAIT: btn_l -> foul_l=1, btn_r -> foul_r=1, then FOUL. Both in the
//   same cycle sets both flags. A button beats a slow_en tick in the same cycle.
//  FOUL: busy=1, flags held. start -> clear flags, GATHER. Other inputs ignored.
//  GO: go=1. The first cycle with a press pulses first_l and/or first_r (both
//   pulse on a tie), go drops, and state returns to IDLE the next cycle.
//  start while in GATHER, WAIT or GO is ignored. Start and buttons arriving
//   together in IDLE: start is taken, buttons are dropped.
//  slow_en arriving while in IDLE, FOUL or GO does not affect the shift reg or cnt.
//  Reset mid-round aborts immediately to IDLE with all outputs cleared.
// CONFIGURATION
//  `define START_REFEREE_TIMEOUT_EN: adds output timeout (1 bit, one-clk pulse)
//   and a GO tick counter. When TIMEOUT_TICKS slow_en ticks pass in GO with no
//   press: pulse timeout, drop go, go to IDLE. A press on the same cycle as the
//   expiring tick wins (first_x pulses, no timeout).
//  Without the macro: no timeout port and no counter; GO waits indefinitely.
// TESTING
//  1 defaults; start, rand_bit 1,0,1,1 on 4 ticks -> go high 1 clk after the
//    13th WAIT tick, busy=1 throughout, no fouls
//  2 btn_r during WAIT tick 5 -> foul_r=1, foul_l=0, go never rises; start
//    clears foul_r and re-enters GATHER
//  3 in GO, btn_l and btn_r same cycle -> first_l=first_r=1 for 1 clk; go=0 and
//    IDLE next cycle
//  4 MIN_DELAY=0, bits 0,0,0,0 -> GATHER goes directly to GO; go rises 1 clk
//    after the 4th tick
//  5 rst_n pulsed low mid-WAIT -> all outputs 0 at once, IDLE; start works
//    normally afterward
//  6 TIMEOUT_EN, TIMEOUT_TICKS=3, no press -> timeout pulse on the 3rd GO tick,
//    go=0; repeat with btn_l on that same tick -> first_l pulses, no timeout

Source files
------------

// File: rtl/start_referee.sv
// rtl/start_referee.sv - Tug of War round referee: random start delay, go, fouls, first press.
// Optional `START_REFEREE_TIMEOUT_EN adds a GO-phase tick timeout and the o_timeout pulse.
module start_referee #(
  parameter int DELAY_BITS    = 4,
  parameter int MIN_DELAY     = 2
`ifdef START_REFEREE_TIMEOUT_EN
  ,parameter int TIMEOUT_TICKS = 32
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_slow_en,
  input  logic i_rand_bit,
  input  logic i_start,
  input  logic i_btn_l,
  input  logic i_btn_r,
  output logic o_go,
  output logic o_foul_l,
  output logic o_foul_r,
  output logic o_first_l,
  output logic o_first_r,
  output logic o_busy
`ifdef START_REFEREE_TIMEOUT_EN
  ,output logic o_timeout
`endif
);

  localparam int CW  = DELAY_BITS + 1;
  localparam int BCW = $clog2(DELAY_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_GATHER, S_WAIT, S_GO, S_FOUL} state_t;

  state_t                r_state;
  logic [DELAY_BITS-2:0] r_shift;
  logic [BCW-1:0]        r_bitcnt;
  logic [CW-1:0]         r_cnt;

  logic                  w_press;
  logic [DELAY_BITS-1:0] w_value;
  logic [CW-1:0]         w_load;
  logic                  w_last_bit;

  // The shift reg only holds the bits gathered so far; the final bit joins them on load.
  assign w_press    = i_btn_l | i_btn_r;
  assign w_value    = {r_shift, i_rand_bit};
  assign w_load     = {1'b0, w_value} + CW'(MIN_DELAY);
  assign w_last_bit = (r_bitcnt == BCW'(DELAY_BITS - 1));

`ifdef START_REFEREE_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_TICKS + 1);
  logic [TCW-1:0] r_gocnt;
  logic           w_expire;
  assign w_expire = (r_gocnt == TCW'(TIMEOUT_TICKS - 1));
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      o_go      <= 1'b0;
      o_foul_l  <= 1'b0;
      o_foul_r  <= 1'b0;
      o_first_l <= 1'b0;
      o_first_r <= 1'b0;
      o_busy    <= 1'b0;
`ifdef START_REFEREE_TIMEOUT_EN
      r_gocnt   <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      o_first_l <= 1'b0;
      o_first_r <= 1'b0;
`ifdef START_REFEREE_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_GATHER;
            r_shift  <= '0;
            r_bitcnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        S_GATHER: begin
          if (w_press) begin
            o_foul_l <= i_btn_l;
            o_foul_r <= i_btn_r;
            r_state  <= S_FOUL;
          end else if (i_slow_en) begin
            if (w_last_bit) begin
              r_cnt <= w_load;
              if (w_load == '0) begin
                r_state <= S_GO;
                o_go    <= 1'b1;
`ifdef START_REFEREE_TIMEOUT_EN
                r_gocnt <= '0;
`endif
              end else begin
                r_state <= S_WAIT;
              end
            end else begin
              r_shift  <= w_value[DELAY_BITS-2:0];
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (w_press) begin
            o_foul_l <= i_btn_l;
            o_foul_r <= i_btn_r;
            r_state  <= S_FOUL;
          end else if (i_slow_en) begin
            if (r_cnt == CW'(1)) begin
              r_cnt   <= '0;
              r_state <= S_GO;
              o_go    <= 1'b1;
`ifdef START_REFEREE_TIMEOUT_EN
              r_gocnt <= '0;
`endif
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_GO: begin
          // A press on the expiring tick wins over the timeout.
          if (w_press) begin
            o_first_l <= i_btn_l;
            o_first_r <= i_btn_r;
            o_go      <= 1'b0;
            o_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
`ifdef START_REFEREE_TIMEOUT_EN
          else if (i_slow_en) begin
            if (w_expire) begin
              o_timeout <= 1'b1;
              o_go      <= 1'b0;
              o_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_gocnt <= r_gocnt + 1'b1;
            end
          end
`endif
        end
        S_FOUL: begin
          if (i_start) begin
            o_foul_l <= 1'b0;
            o_foul_r <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_state  <= S_GATHER;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_go    <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_referee.sv
// tb/tb_start_referee.sv - Self-checking bench for start_referee (default and MIN_DELAY=0 instances).
// Honours `START_REFEREE_TIMEOUT_EN to also exercise the timeout output.
module tb_start_referee;

  localparam int DB = 4;
`ifdef START_REFEREE_TIMEOUT_EN
  localparam int TO   = 3;
  localparam int NSIG = 7;
`else
  localparam int NSIG = 6;
`endif

  localparam int P_IDLE = 0, P_GATHER = 1, P_WAIT = 2, P_GO = 3, P_FOUL = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sl = 1'b0, rb = 1'b0, st = 1'b0, bl = 1'b0, br = 1'b0;
  logic a_go, a_fl, a_fr, a_1l, a_1r, a_busy, a_to;
  logic z_go, z_fl, z_fr, z_1l, z_1r, z_busy, z_to;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

`ifdef START_REFEREE_TIMEOUT_EN
  start_referee #(.DELAY_BITS(DB), .MIN_DELAY(2), .TIMEOUT_TICKS(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_slow_en(sl), .i_rand_bit(rb), .i_start(st),
    .i_btn_l(bl), .i_btn_r(br), .o_go(a_go), .o_foul_l(a_fl), .o_foul_r(a_fr),
    .o_first_l(a_1l), .o_first_r(a_1r), .o_busy(a_busy), .o_timeout(a_to));
  start_referee #(.DELAY_BITS(DB), .MIN_DELAY(0), .TIMEOUT_TICKS(TO)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_slow_en(sl), .i_rand_bit(rb), .i_start(st),
    .i_btn_l(bl), .i_btn_r(br), .o_go(z_go), .o_foul_l(z_fl), .o_foul_r(z_fr),
    .o_first_l(z_1l), .o_first_r(z_1r), .o_busy(z_busy), .o_timeout(z_to));
`else
  start_referee #(.DELAY_BITS(DB), .MIN_DELAY(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_slow_en(sl), .i_rand_bit(rb), .i_start(st),
    .i_btn_l(bl), .i_btn_r(br), .o_go(a_go), .o_foul_l(a_fl), .o_foul_r(a_fr),
    .o_first_l(a_1l), .o_first_r(a_1r), .o_busy(a_busy));
  start_referee #(.DELAY_BITS(DB), .MIN_DELAY(0)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_slow_en(sl), .i_rand_bit(rb), .i_start(st),
    .i_btn_l(bl), .i_btn_r(br), .o_go(z_go), .o_foul_l(z_fl), .o_foul_r(z_fr),
    .o_first_l(z_1l), .o_first_r(z_1r), .o_busy(z_busy));
  assign a_to = 1'b0;
  assign z_to = 1'b0;
`endif

  // Round model: phase, gathered value, remaining ticks, GO ticks, per instance.
  int ph[2], nb[2], val[2], rem[2], gt[2];
  logic e_go[2], e_fl[2], e_fr[2], e_1l[2], e_1r[2], e_busy[2], e_to[2];
  string nm[7] = '{"go", "foul_l", "foul_r", "first_l", "first_r", "busy", "timeout"};

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_IDLE; nb[k] = 0; val[k] = 0; rem[k] = 0; gt[k] = 0;
      e_go[k] = 0; e_fl[k] = 0; e_fr[k] = 0; e_1l[k] = 0; e_1r[k] = 0;
      e_busy[k] = 0; e_to[k] = 0;
    end
  endtask

  task automatic model_step(input logic s_sl, s_rb, s_st, s_bl, s_br);
    for (int k = 0; k < 2; k++) begin
      int md;
      md = (k == 0) ? 2 : 0;
      e_1l[k] = 0; e_1r[k] = 0; e_to[k] = 0;
      case (ph[k])
        P_IDLE: if (s_st) begin ph[k] = P_GATHER; nb[k] = 0; val[k] = 0; end
        P_GATHER, P_WAIT: begin
          if (s_bl || s_br) begin
            if (s_bl) e_fl[k] = 1;
            if (s_br) e_fr[k] = 1;
            ph[k] = P_FOUL;
          end else if (s_sl) begin
            if (ph[k] == P_GATHER) begin
              val[k] = val[k] * 2 + int'(s_rb);
              nb[k]++;
              if (nb[k] == DB) begin
                rem[k] = val[k] + md;
                gt[k]  = 0;
                ph[k]  = (rem[k] == 0) ? P_GO : P_WAIT;
              end
            end else begin
              rem[k]--;
              if (rem[k] == 0) begin ph[k] = P_GO; gt[k] = 0; end
            end
          end
        end
        P_GO: begin
          if (s_bl || s_br) begin
            e_1l[k] = s_bl; e_1r[k] = s_br; ph[k] = P_IDLE;
          end
`ifdef START_REFEREE_TIMEOUT_EN
          else if (s_sl) begin
            gt[k]++;
            if (gt[k] == TO) begin e_to[k] = 1; ph[k] = P_IDLE; end
          end
`endif
        end
        P_FOUL: if (s_st) begin
          e_fl[k] = 0; e_fr[k] = 0; ph[k] = P_GATHER; nb[k] = 0; val[k] = 0;
        end
        default: ph[k] = P_IDLE;
      endcase
      e_go[k]   = (ph[k] == P_GO);
      e_busy[k] = (ph[k] != P_IDLE);
    end
  endtask

  task automatic compare_all();
    logic [6:0] act, exp;
    for (int k = 0; k < 2; k++) begin
      act = (k == 0) ? {a_go, a_fl, a_fr, a_1l, a_1r, a_busy, a_to}
                     : {z_go, z_fl, z_fr, z_1l, z_1r, z_busy, z_to};
      exp = {e_go[k], e_fl[k], e_fr[k], e_1l[k], e_1r[k], e_busy[k], e_to[k]};
      for (int i = 0; i < NSIG; i++)
        chk($sformatf("%s_%s", (k == 0) ? "md2" : "md0", nm[i]), act[6-i], exp[6-i]);
    end
  endtask

  // Called just after an active edge; inputs are applied for the next edge.
  task automatic step(input logic s_sl, s_rb, s_st, s_bl, s_br);
    sl = s_sl; rb = s_rb; st = s_st; bl = s_bl; br = s_br;
    model_step(s_sl, s_rb, s_st, s_bl, s_br);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic tick(input logic b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    sl = 0; rb = 0; st = 0; bl = 0; br = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    #2;
    chk("reset_go", a_go, 1'b0);
    chk("reset_busy", a_busy, 1'b0);
    chk("reset_fouls", a_fl | a_fr, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();

    // Bits 1,0,1,1 -> value 11, delay 13 WAIT ticks on the default instance.
    step(0, 0, 1, 0, 0);
    tick(1); tick(0); tick(1); tick(1);
    chk("t1_busy", a_busy, 1'b1);
    chk("t1_go_before", a_go, 1'b0);
    n = 0;
    while (a_go !== 1'b1 && n < 40) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    chk_int("t1_wait_ticks", n, 13);
    chk("t1_no_foul", a_fl | a_fr, 1'b0);

    // Tie in GO.
    step(0, 0, 0, 1, 1);
    chk("t3_first_l", a_1l, 1'b1);
    chk("t3_first_r", a_1r, 1'b1);
    chk("t3_go_drop", a_go, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("t3_first_l_pulse", a_1l, 1'b0);
    chk("t3_idle", a_busy, 1'b0);

    // Foul on WAIT tick 5.
    step(0, 0, 1, 0, 0);
    tick(1); tick(1); tick(1); tick(1);
    for (int i = 0; i < 4; i++) tick(0);
    step(1, 0, 0, 0, 1);
    chk("t2_foul_r", a_fr, 1'b1);
    chk("t2_foul_l", a_fl, 1'b0);
    for (int i = 0; i < 20; i++) tick(0);
    chk("t2_foul_held", a_fr, 1'b1);
    chk("t2_no_go", a_go, 1'b0);
    step(0, 0, 1, 0, 0);
    chk("t2_foul_clear", a_fr, 1'b0);
    chk("t2_regather", a_busy, 1'b1);

    // Zero delay on the MIN_DELAY=0 instance.
    tick(0); tick(0); tick(0);
    step(1, 0, 0, 0, 0);
    chk("t4_z_go", z_go, 1'b1);
    chk("t4_a_wait", a_go, 1'b0);
    step(0, 0, 0, 1, 0);
    chk("t4_z_first_l", z_1l, 1'b1);
    chk("t4_a_foul_l", a_fl, 1'b1);

    // Reset in the middle of WAIT.
    step(0, 0, 1, 0, 0);
    tick(1); tick(1); tick(1); tick(1); tick(0); tick(0);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_go", a_go, 1'b0);
    chk("t5_foul", a_fl | a_fr, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0);
    chk("t5_restart", a_busy, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 23) == 0,
           $urandom_range(0, 89) == 0, $urandom_range(0, 89) == 0);
    end

`ifdef START_REFEREE_TIMEOUT_EN
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      step(0, 0, 1, 0, 0);
      tick(0); tick(0); tick(0); tick(0);
      tick(0); tick(0);
      chk("t6_go", a_go, 1'b1);
      tick(0); tick(0);
      if (rep == 0) begin
        step(1, 0, 0, 0, 0);
        chk("t6_timeout", a_to, 1'b1);
        chk("t6_go_drop", a_go, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("t6_timeout_pulse", a_to, 1'b0);
      end else begin
        step(1, 0, 0, 1, 0);
        chk("t6_press_wins", a_1l, 1'b1);
        chk("t6_no_timeout", a_to, 1'b0);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
